aes_ct_readout: RTL and testbench
=================================

AES_CT_READOUT -- requirements
Module: aes_ct_readout

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, the number of HOLD cycles before an unread ciphertext is scrubbed (range 2..65535).
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port ct_i, input, 128, ciphertext from the AES core.
REQ-005 SHALL have port ct_valid_i, input, 1, ciphertext-valid strobe from the AES core.
REQ-006 SHALL have port ct_ready_o, output, 1, high when the block can capture a ciphertext.
REQ-007 SHALL have port en_i, input, 1, bus access enable.
REQ-008 SHALL have port we_i, input, 1, bus write (1) / read (0).
REQ-009 SHALL have port address_i, input, 9, bus address; word index is address_i[8:3].
REQ-010 SHALL have port wdata_i, input, 32, bus write data.
REQ-011 SHALL have port reglk_ctrl_i, input, 8, register-lock controls; bit 5 locks ciphertext reads.
REQ-012 SHALL have port rdata_o, output, 32, registered bus read data.
REQ-013 SHALL have port busy_o, output, 1, high in HOLD or SCRUB.

Function
REQ-014 SHALL implement FSM states IDLE, HOLD, SCRUB.
- IDLE: ct_ready_o=1. ct_valid_i=1 captures ct_i into buffer, clears read mask and timer, goes to HOLD.
- HOLD: ct_ready_o=0. Goes to SCRUB on any of: all four words read, timer reaching TIMEOUT_CYCLES-1, or a flush write.
- SCRUB: lasts exactly one cycle, zeroes the buffer, mask and timer, then returns to IDLE.
REQ-015 SHALL map the read window (en_i=1, we_i=0) as:
- index 5 -> ct[127:96]
- index 6 -> ct[95:64]
- index 7 -> ct[63:32]
- index 8 -> ct[31:0]
- index 9 -> status {27'b0, overrun, mask[3:0]}
- any other index -> 0
REQ-016 SHALL present read data on rdata_o one cycle after the request, and drive rdata_o to 0 in every cycle without a read request.
REQ-017 SHALL, on a ciphertext read in HOLD with reglk_ctrl_i[5]=0, return the word and set its mask bit; repeated reads of the same word SHALL be allowed and leave the mask unchanged.
REQ-018 SHALL return 0 and leave the mask unchanged for ciphertext reads outside HOLD or with reglk_ctrl_i[5]=1.
REQ-019 SHALL treat a write to index 10 with wdata_i[0]=1 as a flush: in HOLD, go to SCRUB; in IDLE or SCRUB, no effect. All other writes SHALL be ignored.
REQ-020 SHALL set a sticky overrun bit when ct_valid_i=1 while not in IDLE; the buffer is not modified. A status read SHALL clear overrun on the cycle after it is returned; if a new overrun occurs in that same cycle, the set wins.
REQ-021 SHALL handle simultaneous completion causes (last-word read, timeout, flush) as one SCRUB; the last word read SHALL still return its true value.
REQ-022 SHALL give a read and a capture in the same IDLE cycle no interaction: the read returns 0 and the capture proceeds.
REQ-023 SHALL use a 16-bit timer that counts only in HOLD and saturates at TIMEOUT_CYCLES-1.
REQ-024 SHALL never present buffer contents on rdata_o except through REQ-017.

Reset
REQ-025 SHALL, on rst_ni=0 at any time (including mid-HOLD), asynchronously clear state to IDLE and zero the buffer, mask, timer, overrun, rdata_o and busy_o; ct_ready_o SHALL be 1 once reset releases.

Structure
REQ-026 SHALL place the state enum, word-index constants (5..10) and lock bit index (5) in package aes_ct_pkg.
REQ-027 SHALL implement the timer as sub-module aes_ct_timer (inputs: clear, run; output: expired).

Verification
REQ-028 SHALL cover capture of ct=0x00112233_44556677_8899AABB_CCDDEEFF, then reads of indices 5,6,7,8 -> 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF each one cycle later; SCRUB follows; a re-read of index 5 -> 0.
REQ-029 SHALL cover TIMEOUT_CYCLES=8 with capture and no reads -> busy_o drops 9 cycles after capture, and the buffer reads 0.
REQ-030 SHALL cover reglk_ctrl_i[5]=1 during HOLD: reads of indices 5..8 -> 0, status mask=0; after unlock, reads return the true data.
REQ-031 SHALL cover a second ct_valid_i during HOLD -> status=0x10 with the original data intact; the status bit clears after it is read.
REQ-032 SHALL cover flush in HOLD -> SCRUB next cycle; rst_ni pulsed mid-HOLD -> IDLE with all outputs 0 and ct_ready_o=1.

Source files
------------

// File: rtl/aes_ct_pkg.sv
// Shared types and constants for the AES ciphertext readout block.
package aes_ct_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_SCRUB = 2'd2
    } state_e;

    localparam logic [5:0] IDX_CT0    = 6'd5;
    localparam logic [5:0] IDX_CT1    = 6'd6;
    localparam logic [5:0] IDX_CT2    = 6'd7;
    localparam logic [5:0] IDX_CT3    = 6'd8;
    localparam logic [5:0] IDX_STATUS = 6'd9;
    localparam logic [5:0] IDX_FLUSH  = 6'd10;

    localparam int unsigned LOCK_CT_BIT = 5;

    // Word 0 is the most significant 32 bits of the ciphertext.
    function automatic logic [31:0] ct_word(input logic [127:0] ct, input logic [1:0] sel);
        logic [31:0] w;
        case (sel)
            2'd0:    w = ct[127:96];
            2'd1:    w = ct[95:64];
            2'd2:    w = ct[63:32];
            default: w = ct[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/aes_ct_timer.sv
// HOLD-time counter: counts while run is high, saturates at TIMEOUT_CYCLES-1.
module aes_ct_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (run && (count_q != LIMIT)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign expired = (count_q == LIMIT);

endmodule

// File: rtl/aes_ct_readout.sv
// Holds one AES ciphertext for bus readout and scrubs it once fully read,
// on timeout, or on flush.
module aes_ct_readout
    import aes_ct_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [127:0] ct_i,
    input  logic         ct_valid_i,
    output logic         ct_ready_o,
    input  logic         en_i,
    input  logic         we_i,
    input  logic [8:0]   address_i,
    input  logic [31:0]  wdata_i,
    input  logic [7:0]   reglk_ctrl_i,
    output logic [31:0]  rdata_o,
    output logic         busy_o
);

    state_e       state_q, state_d;
    logic [127:0] ct_q;
    logic [3:0]   mask_q, mask_nxt;
    logic         overrun_q;
    logic [31:0]  rdata_nxt;

    logic [5:0]   idx;
    logic [1:0]   sel;
    logic         rd_req, is_ct_idx, ct_rd_ok, status_rd, flush_req;
    logic         capture, done, expired;

    logic         unused_bits;
    assign unused_bits = ^{address_i[2:0], wdata_i[31:1], reglk_ctrl_i[7:6], reglk_ctrl_i[4:0]};

    assign idx       = address_i[8:3];
    assign sel       = 2'(idx - IDX_CT0);
    assign rd_req    = en_i && !we_i;
    assign is_ct_idx = (idx >= IDX_CT0) && (idx <= IDX_CT3);
    assign ct_rd_ok  = rd_req && is_ct_idx && (state_q == ST_HOLD) && !reglk_ctrl_i[LOCK_CT_BIT];
    assign status_rd = rd_req && (idx == IDX_STATUS);
    assign flush_req = en_i && we_i && (idx == IDX_FLUSH) && wdata_i[0];
    assign capture   = (state_q == ST_IDLE) && ct_valid_i;

    assign mask_nxt  = ct_rd_ok ? (mask_q | (4'b0001 << sel)) : mask_q;
    // Completion is judged on the post-read mask so the last read and SCRUB share one edge.
    assign done      = (ct_rd_ok && (mask_nxt == 4'hF)) || expired || flush_req;

    aes_ct_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clear  (capture || (state_q == ST_SCRUB)),
        .run    (state_q == ST_HOLD),
        .expired(expired)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (ct_valid_i) state_d = ST_HOLD;
            ST_HOLD:  if (done) state_d = ST_SCRUB;
            ST_SCRUB: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ct_ready_o = (state_q == ST_IDLE);
        busy_o     = (state_q != ST_IDLE);
    end

    always_comb begin
        rdata_nxt = '0;
        if (ct_rd_ok) begin
            rdata_nxt = ct_word(ct_q, sel);
        end else if (status_rd) begin
            rdata_nxt = {27'b0, overrun_q, mask_q};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ct_q      <= '0;
            mask_q    <= '0;
            overrun_q <= 1'b0;
            rdata_o   <= '0;
        end else begin
            rdata_o <= rdata_nxt;
            if (state_q == ST_SCRUB) begin
                ct_q   <= '0;
                mask_q <= '0;
            end else if (capture) begin
                ct_q   <= ct_i;
                mask_q <= '0;
            end else begin
                mask_q <= mask_nxt;
            end
            if (ct_valid_i && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end else if (status_rd) begin
                overrun_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aes_ct_readout.sv
// Directed bench for aes_ct_readout: read results are queued when requested
// and compared when they appear on rdata_o.
module tb_aes_ct_readout;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic [127:0] ct_i = '0;
    logic         ct_valid_i = 1'b0;
    logic         ct_valid_t8 = 1'b0;
    logic         en_i = 1'b0;
    logic         we_i = 1'b0;
    logic [8:0]   address_i = '0;
    logic [31:0]  wdata_i = '0;
    logic [7:0]   reglk_ctrl_i = '0;
    logic         ct_ready_o, ct_ready_t8;
    logic [31:0]  rdata_o, rdata_t8;
    logic         busy_o, busy_t8;

    int errors = 0;
    int checks = 0;
    logic [31:0] sb_q[$];
    string       tag_q[$];

    always #5 clk_i = ~clk_i;

    aes_ct_readout dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .ct_i(ct_i), .ct_valid_i(ct_valid_i),
        .ct_ready_o(ct_ready_o), .en_i(en_i), .we_i(we_i), .address_i(address_i),
        .wdata_i(wdata_i), .reglk_ctrl_i(reglk_ctrl_i), .rdata_o(rdata_o), .busy_o(busy_o)
    );

    aes_ct_readout #(.TIMEOUT_CYCLES(8)) dut_t8 (
        .clk_i(clk_i), .rst_ni(rst_ni), .ct_i(ct_i), .ct_valid_i(ct_valid_t8),
        .ct_ready_o(ct_ready_t8), .en_i(en_i), .we_i(we_i), .address_i(address_i),
        .wdata_i(wdata_i), .reglk_ctrl_i(reglk_ctrl_i), .rdata_o(rdata_t8), .busy_o(busy_t8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input bit t8, input logic [5:0] idx, input logic [31:0] exp, input string tag);
        @(negedge clk_i);
        en_i = 1'b1; we_i = 1'b0; address_i = {idx, 3'b000};
        sb_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk_i); #1;
        en_i = 1'b0;
        chk(tag_q.pop_front(), t8 ? rdata_t8 : rdata_o, sb_q.pop_front());
    endtask

    task automatic wr(input logic [5:0] idx, input logic [31:0] data);
        @(negedge clk_i);
        en_i = 1'b1; we_i = 1'b1; address_i = {idx, 3'b000}; wdata_i = data;
        @(posedge clk_i); #1;
        en_i = 1'b0; we_i = 1'b0; wdata_i = '0;
    endtask

    task automatic cap(input logic [127:0] ct);
        @(negedge clk_i);
        ct_i = ct; ct_valid_i = 1'b1;
        @(posedge clk_i); #1;
        ct_valid_i = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk_i); #1;
    endtask

    localparam logic [127:0] CT1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] CT2 = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
    localparam logic [127:0] CT3 = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] CT4 = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
    localparam logic [127:0] JUNK = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;

    initial begin
        int n;
        // Reset state
        #12;
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_busy", {31'b0, busy_o}, 32'h0);
        chk("rst_ready", {31'b0, ct_ready_o}, 32'h1);
        @(negedge clk_i); rst_ni = 1'b1;
        idle_cycle();
        chk("idle_rdata", rdata_o, 32'h0);

        // Full readout then scrub
        cap(CT1);
        chk("hold_busy", {31'b0, busy_o}, 32'h1);
        chk("hold_ready", {31'b0, ct_ready_o}, 32'h0);
        rd(0, 6'd5, 32'h00112233, "ct1_w0");
        rd(0, 6'd6, 32'h44556677, "ct1_w1");
        rd(0, 6'd7, 32'h8899AABB, "ct1_w2");
        rd(0, 6'd8, 32'hCCDDEEFF, "ct1_w3");
        chk("scrub_busy", {31'b0, busy_o}, 32'h1);
        rd(0, 6'd5, 32'h0, "ct1_reread");
        chk("post_scrub_busy", {31'b0, busy_o}, 32'h0);
        chk("post_scrub_ready", {31'b0, ct_ready_o}, 32'h1);
        rd(0, 6'd9, 32'h0, "ct1_status_after");

        // Register lock
        cap(CT2);
        reglk_ctrl_i = 8'h20;
        rd(0, 6'd5, 32'h0, "lk_w0");
        rd(0, 6'd6, 32'h0, "lk_w1");
        rd(0, 6'd7, 32'h0, "lk_w2");
        rd(0, 6'd8, 32'h0, "lk_w3");
        rd(0, 6'd9, 32'h0, "lk_status");
        reglk_ctrl_i = 8'h00;
        rd(0, 6'd3, 32'h0, "unmapped_3");
        rd(0, 6'd11, 32'h0, "unmapped_11");
        rd(0, 6'd5, 32'hDEADBEEF, "ulk_w0");
        rd(0, 6'd6, 32'h01234567, "ulk_w1");
        rd(0, 6'd7, 32'h89ABCDEF, "ulk_w2");
        rd(0, 6'd8, 32'hFEDCBA98, "ulk_w3");
        idle_cycle();
        chk("lk_done_busy", {31'b0, busy_o}, 32'h0);

        // Read and capture in the same IDLE cycle, then overrun
        @(negedge clk_i);
        ct_i = CT3; ct_valid_i = 1'b1;
        en_i = 1'b1; we_i = 1'b0; address_i = {6'd5, 3'b000};
        sb_q.push_back(32'h0); tag_q.push_back("cap_and_read");
        @(posedge clk_i); #1;
        ct_valid_i = 1'b0; en_i = 1'b0;
        chk(tag_q.pop_front(), rdata_o, sb_q.pop_front());
        chk("cap_and_read_busy", {31'b0, busy_o}, 32'h1);
        rd(0, 6'd5, 32'h11111111, "ct3_w0");
        rd(0, 6'd5, 32'h11111111, "ct3_w0_again");
        rd(0, 6'd9, 32'h00000001, "ct3_mask");
        @(negedge clk_i); ct_i = JUNK; ct_valid_i = 1'b1;
        @(posedge clk_i); #1; ct_valid_i = 1'b0;
        rd(0, 6'd9, 32'h00000011, "ovr_status");
        rd(0, 6'd9, 32'h00000001, "ovr_cleared");
        rd(0, 6'd6, 32'h22222222, "ct3_w1");
        rd(0, 6'd7, 32'h33333333, "ct3_w2");
        rd(0, 6'd8, 32'h44444444, "ct3_w3");
        idle_cycle();
        chk("ct3_done_busy", {31'b0, busy_o}, 32'h0);

        // Flush
        cap(CT4);
        wr(6'd10, 32'h0);
        chk("flush0_busy", {31'b0, busy_o}, 32'h1);
        wr(6'd11, 32'h1);
        rd(0, 6'd5, 32'hA5A5A5A5, "ct4_w0");
        wr(6'd10, 32'h1);
        chk("flush_scrub_busy", {31'b0, busy_o}, 32'h1);
        rd(0, 6'd6, 32'h0, "flush_read");
        chk("flush_idle_busy", {31'b0, busy_o}, 32'h0);
        rd(0, 6'd9, 32'h0, "flush_status");
        wr(6'd10, 32'h1);
        chk("flush_idle_noeffect", {31'b0, busy_o}, 32'h0);

        // Reset mid-HOLD
        cap(CT1);
        rd(0, 6'd5, 32'h00112233, "prerst_w0");
        @(negedge clk_i); ct_valid_i = 1'b1;
        @(posedge clk_i); #1; ct_valid_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        chk("midrst_rdata", rdata_o, 32'h0);
        chk("midrst_busy", {31'b0, busy_o}, 32'h0);
        chk("midrst_ready", {31'b0, ct_ready_o}, 32'h1);
        @(negedge clk_i); rst_ni = 1'b1;
        rd(0, 6'd9, 32'h0, "midrst_status");
        rd(0, 6'd5, 32'h0, "midrst_w0");

        // Timeout with TIMEOUT_CYCLES=8
        @(negedge clk_i); ct_i = CT2; ct_valid_t8 = 1'b1;
        @(posedge clk_i); #1; ct_valid_t8 = 1'b0;
        chk("t8_busy", {31'b0, busy_t8}, 32'h1);
        n = 0;
        while (busy_t8 && n < 40) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk("t8_busy_drop_cycles", 32'(n), 32'd9);
        rd(1, 6'd5, 32'h0, "t8_w0");
        rd(1, 6'd8, 32'h0, "t8_w3");
        rd(1, 6'd9, 32'h0, "t8_status");

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
